tlul_fifo_param: RTL and testbench

- Parametrised TL-UL pass-through buffer between one host port and one device port.
- A-channel request FIFO and D-channel response FIFO, each with independent depth.
- Field widths are generic, not fixed at 32/32/8/1/16/16. Includes an outstanding-transaction limiter.
- Placed at crossbar/peripheral boundaries (e.g. in front of rv_plic) for timing isolation and request throttling.

---
 rtl/tlul_fifo_param.sv | 165 ++++++++++++++++
 tb/tb_tlul_fifo_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tlul_fifo_param.sv
// TL-UL pass-through buffer: independent A/D FIFOs plus an outstanding-request limiter.
// Optional occupancy/status outputs are enabled with the TLUL_FIFO_STATUS_EN macro.

module tlul_fifo_param_ch #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int CW   = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_pld,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_pld,
  output logic [CW-1:0] occ
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid && !rst;
    assign in_ready  = out_ready && !rst;
    assign out_pld   = in_pld;
    assign occ       = '0;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  mem [DEPTH];
    logic          full, push, pop;

    // Explicit wrap so non-power-of-two depths stay in range
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (cnt == CW'(DEPTH));
    assign in_ready  = !rst && !full;
    assign out_valid = !rst && (cnt != '0);
    assign out_pld   = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occ       = cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      cnt <= cnt + CW'(1);
        else if (pop && !push) cnt <= cnt - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_pld;
    end
  end

endmodule

module tlul_fifo_param #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int AIW       = 8,
  parameter int DIW       = 1,
  parameter int AUW       = 16,
  parameter int DUW       = 16,
  parameter int REQ_DEPTH = 2,
  parameter int RSP_DEPTH = 2,
  parameter int MAX_OUTST = 4,
  localparam int DBW = DW / 8,
  localparam int SZW = $clog2($clog2(DBW) + 1),
  localparam int AP  = 3 + 3 + SZW + AIW + AW + DBW + DW + AUW,
  localparam int DP  = 3 + 3 + SZW + AIW + DIW + DW + DUW + 1,
  localparam int RCW = (REQ_DEPTH > 0) ? $clog2(REQ_DEPTH + 1) : 1,
  localparam int DCW = (RSP_DEPTH > 0) ? $clog2(RSP_DEPTH + 1) : 1,
  localparam int OW  = $clog2(MAX_OUTST + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          h_a_valid_i,
  output logic          h_a_ready_o,
  input  logic [AP-1:0] h_a_pld_i,
  output logic          d_a_valid_o,
  input  logic          d_a_ready_i,
  output logic [AP-1:0] d_a_pld_o,
  input  logic          d_d_valid_i,
  output logic          d_d_ready_o,
  input  logic [DP-1:0] d_d_pld_i,
  output logic          h_d_valid_o,
  input  logic          h_d_ready_i,
  output logic [DP-1:0] h_d_pld_o
`ifdef TLUL_FIFO_STATUS_EN
  ,
  output logic [RCW-1:0] req_cnt_o,
  output logic [DCW-1:0] rsp_cnt_o,
  output logic [OW-1:0]  outst_o
`endif
);

  logic [OW-1:0] outst_q;
  logic          outst_ok;
  logic          a_in_ready;
  logic          a_hs, d_hs;

  function automatic logic [OW-1:0] sat_step(input logic [OW-1:0] cur,
                                             input logic inc, input logic dec);
    if (inc && !dec && cur != OW'(MAX_OUTST)) return cur + OW'(1);
    if (dec && !inc && cur != '0)             return cur - OW'(1);
    return cur;
  endfunction

  // Limiter gates the host side only; ready depends on registered count
  assign outst_ok    = (outst_q < OW'(MAX_OUTST));
  assign h_a_ready_o = a_in_ready && outst_ok;
  assign a_hs        = h_a_valid_i && h_a_ready_o;
  assign d_hs        = h_d_valid_o && h_d_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) outst_q <= '0;
    else       outst_q <= sat_step(outst_q, a_hs, d_hs);
  end

  tlul_fifo_param_ch #(.W(AP), .DEPTH(REQ_DEPTH)) u_req (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (h_a_valid_i && outst_ok),
    .in_ready  (a_in_ready),
    .in_pld    (h_a_pld_i),
    .out_valid (d_a_valid_o),
    .out_ready (d_a_ready_i),
    .out_pld   (d_a_pld_o),
`ifdef TLUL_FIFO_STATUS_EN
    .occ       (req_cnt_o)
`else
    .occ       ()
`endif
  );

  tlul_fifo_param_ch #(.W(DP), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (d_d_valid_i),
    .in_ready  (d_d_ready_o),
    .in_pld    (d_d_pld_i),
    .out_valid (h_d_valid_o),
    .out_ready (h_d_ready_i),
    .out_pld   (h_d_pld_o),
`ifdef TLUL_FIFO_STATUS_EN
    .occ       (rsp_cnt_o)
`else
    .occ       ()
`endif
  );

`ifdef TLUL_FIFO_STATUS_EN
  assign outst_o = outst_q;
`endif

endmodule

// File: tb/tb_tlul_fifo_param.sv
// Directed bench for tlul_fifo_param: buffered instance (2/3/4) and pass-through instance (0/0/2).
module tb_tlul_fifo_param;
  localparam int AP = 100;
  localparam int DP = 66;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          h_a_valid, h_a_ready, d_a_valid, d_a_ready;
  logic          d_d_valid, d_d_ready, h_d_valid, h_d_ready;
  logic [AP-1:0] h_a_pld, d_a_pld;
  logic [DP-1:0] d_d_pld, h_d_pld;

  logic          h_a_valid1, h_a_ready1, d_a_valid1, d_a_ready1;
  logic          d_d_valid1, d_d_ready1, h_d_valid1, h_d_ready1;
  logic [AP-1:0] h_a_pld1, d_a_pld1;
  logic [DP-1:0] d_d_pld1, h_d_pld1;

`ifdef TLUL_FIFO_STATUS_EN
  logic [1:0] req_cnt0, rsp_cnt0;
  logic [2:0] outst0;
  logic       req_cnt1, rsp_cnt1;
  logic [1:0] outst1;
`endif

  tlul_fifo_param #(.REQ_DEPTH(2), .RSP_DEPTH(3), .MAX_OUTST(4)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .h_a_valid_i(h_a_valid), .h_a_ready_o(h_a_ready), .h_a_pld_i(h_a_pld),
    .d_a_valid_o(d_a_valid), .d_a_ready_i(d_a_ready), .d_a_pld_o(d_a_pld),
    .d_d_valid_i(d_d_valid), .d_d_ready_o(d_d_ready), .d_d_pld_i(d_d_pld),
    .h_d_valid_o(h_d_valid), .h_d_ready_i(h_d_ready), .h_d_pld_o(h_d_pld)
`ifdef TLUL_FIFO_STATUS_EN
    , .req_cnt_o(req_cnt0), .rsp_cnt_o(rsp_cnt0), .outst_o(outst0)
`endif
  );

  tlul_fifo_param #(.REQ_DEPTH(0), .RSP_DEPTH(0), .MAX_OUTST(2)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .h_a_valid_i(h_a_valid1), .h_a_ready_o(h_a_ready1), .h_a_pld_i(h_a_pld1),
    .d_a_valid_o(d_a_valid1), .d_a_ready_i(d_a_ready1), .d_a_pld_o(d_a_pld1),
    .d_d_valid_i(d_d_valid1), .d_d_ready_o(d_d_ready1), .d_d_pld_i(d_d_pld1),
    .h_d_valid_o(h_d_valid1), .h_d_ready_i(h_d_ready1), .h_d_pld_o(h_d_pld1)
`ifdef TLUL_FIFO_STATUS_EN
    , .req_cnt_o(req_cnt1), .rsp_cnt_o(rsp_cnt1), .outst_o(outst1)
`endif
  );

  int passed = 0;
  int total  = 0;

  function automatic logic [AP-1:0] mk_a(input logic [7:0] src, input logic [31:0] addr,
                                         input logic [31:0] data);
    return {3'd4, 3'd0, 2'd2, src, addr, 4'hF, data, 16'hA5C3};
  endfunction

  function automatic logic [DP-1:0] mk_d(input logic [7:0] src, input logic [31:0] data,
                                         input logic err);
    return {3'd1, 3'd0, 2'd2, src, 1'b1, data, 16'h5A3C, err};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [AP-1:0] a0, a1, a2, a3, a4, a5, a6, a7, ax;
  logic [DP-1:0] r0, r1, r2, r3, r4, r5, rx;

  initial begin
    a0 = mk_a(8'h01, 32'h100, 32'h1111_1111);
    a1 = mk_a(8'h02, 32'h104, 32'h2222_2222);
    a2 = mk_a(8'h03, 32'h108, 32'h3333_3333);
    a3 = mk_a(8'h04, 32'h10C, 32'h4444_4444);
    a4 = mk_a(8'h05, 32'h110, 32'h5555_5555);
    a5 = mk_a(8'h06, 32'h200, 32'h6666_6666);
    a6 = mk_a(8'h07, 32'h204, 32'h7777_7777);
    a7 = mk_a(8'h08, 32'h300, 32'h8888_8888);
    ax = mk_a(8'hFE, 32'hCAFE_0000, 32'h0123_4567);
    r0 = mk_d(8'h03, 32'hDEAD_BEEF, 1'b1);
    r1 = mk_d(8'h11, 32'h0000_0001, 1'b0);
    r2 = mk_d(8'h12, 32'h0000_0002, 1'b1);
    r3 = mk_d(8'h13, 32'h0000_0003, 1'b0);
    r4 = mk_d(8'h14, 32'h0000_0004, 1'b1);
    r5 = mk_d(8'h15, 32'h0000_0005, 1'b0);
    rx = mk_d(8'hEE, 32'h89AB_CDEF, 1'b1);

    rst = 1'b1;
    h_a_valid = 0; d_a_ready = 0; d_d_valid = 0; h_d_ready = 0;
    h_a_pld = '0; d_d_pld = '0;
    h_a_valid1 = 0; d_a_ready1 = 0; d_d_valid1 = 0; h_d_ready1 = 0;
    h_a_pld1 = '0; d_d_pld1 = '0;
    step(); step();
    chk("rst_h_a_ready", h_a_ready, 0);
    chk("rst_d_a_valid", d_a_valid, 0);
    chk("rst_h_d_valid", h_d_valid, 0);
    chk("rst_d_d_ready", d_d_ready, 0);

    rst = 1'b0; #1;
    chk("idle_h_a_ready", h_a_ready, 1);
    chk("idle_d_a_valid", d_a_valid, 0);
    chk("idle_h_d_valid", h_d_valid, 0);
    chk("idle_d_d_ready", d_d_ready, 1);

    // A FIFO fill with device stalled, then ordered drain
    h_a_valid = 1; h_a_pld = a0; step();
    chk("push1_ready", h_a_ready, 1);
    chk("push1_dvalid", d_a_valid, 1);
    chk("push1_pld", d_a_pld, a0);
    h_a_pld = a1; step();
    chk("full_ready", h_a_ready, 0);
    h_a_valid = 0; d_a_ready = 1; #1;
    chk("ord0_pld", d_a_pld, a0);
    step();
    chk("ord1_valid", d_a_valid, 1);
    chk("ord1_pld", d_a_pld, a1);
    chk("notfull_ready", h_a_ready, 1);
    step();
    chk("drain_valid", d_a_valid, 0);

    // Outstanding limit: two already outstanding, two more reach 4
    h_a_valid = 1; h_a_pld = a2; step();
    h_a_pld = a3; step();
    chk("lim_ready", h_a_ready, 0);
    chk("lim_pld", d_a_pld, a3);
    h_a_pld = a4; step();
    chk("lim_ready2", h_a_ready, 0);
    chk("lim_drain", d_a_valid, 0);
    step();
    chk("lim_none", d_a_valid, 0);

    d_d_valid = 1; d_d_pld = r0; step();
    d_d_valid = 0;
    chk("rsp_valid", h_d_valid, 1);
    chk("rsp_pld", h_d_pld, r0);
    chk("rsp_err", h_d_pld[0], 1);
    chk("pre_ready", h_a_ready, 0);
    h_d_ready = 1; step();
    chk("post_ready", h_a_ready, 1);
    h_a_valid = 0; h_d_ready = 0;
    chk("rsp_empty", h_d_valid, 0);

    // D FIFO full: simultaneous push/pop must only pop
    d_d_valid = 1; d_d_pld = r1; step();
    d_d_pld = r2; step();
    d_d_pld = r3; step();
    chk("rfull_dready", d_d_ready, 0);
    chk("rfull_hvalid", h_d_valid, 1);
    chk("rfull_head", h_d_pld, r1);
    d_d_pld = r4; h_d_ready = 1; #1;
    chk("simul_dready", d_d_ready, 0);
    step();
    chk("simul_head", h_d_pld, r2);
    chk("simul_dready_after", d_d_ready, 1);
    d_d_valid = 0; h_d_ready = 0;

    // Reset with entries in both FIFOs
    d_a_ready = 0; h_a_valid = 1; h_a_pld = a5; step();
    h_a_pld = a6; step();
    h_a_valid = 0;
    chk("pre_rst_full", h_a_ready, 0);
    rst = 1; step();
    chk("inrst_h_a_ready", h_a_ready, 0);
    chk("inrst_d_a_valid", d_a_valid, 0);
    chk("inrst_h_d_valid", h_d_valid, 0);
    chk("inrst_d_d_ready", d_d_ready, 0);
    rst = 0; d_a_ready = 1; #1;
    chk("postrst_d_a_valid", d_a_valid, 0);
    chk("postrst_h_d_valid", h_d_valid, 0);
    chk("postrst_h_a_ready", h_a_ready, 1);
    h_a_valid = 1; h_a_pld = a7; step();
    h_a_valid = 0;
    chk("newreq_pld", d_a_pld, a7);
    step();
    d_d_valid = 1; d_d_pld = r5; step();
    d_d_valid = 0;
    chk("newrsp_pld", h_d_pld, r5);
    h_d_ready = 1; step();
    h_d_ready = 0;
    chk("newrsp_empty", h_d_valid, 0);
    h_a_valid = 1; h_a_pld = a0;
    step(); step(); step();
    chk("cnt3_ready", h_a_ready, 1);
    step();
    chk("cnt4_ready", h_a_ready, 0);
    h_a_valid = 0;

    // Pass-through instance
    h_a_valid1 = 1; h_a_pld1 = ax; #1;
    chk("pt_dvalid", d_a_valid1, 1);
    chk("pt_pld", d_a_pld1, ax);
    chk("pt_ready_low", h_a_ready1, 0);
    d_a_ready1 = 1; #1;
    chk("pt_ready_follow", h_a_ready1, 1);
    step(); step();
    chk("pt_lim_ready", h_a_ready1, 0);
    chk("pt_lim_dvalid", d_a_valid1, 0);
    h_a_valid1 = 0;
    d_d_valid1 = 1; d_d_pld1 = rx; #1;
    chk("pt_hdvalid", h_d_valid1, 1);
    chk("pt_hdpld", h_d_pld1, rx);
    chk("pt_ddready_low", d_d_ready1, 0);
    h_d_ready1 = 1; #1;
    chk("pt_ddready_follow", d_d_ready1, 1);
    step();
    d_d_valid1 = 0; h_d_ready1 = 0;
    chk("pt_after_rsp", h_a_ready1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
